// File: rtl/dvp_capture_seq.sv
// rtl/dvp_capture_seq.sv - DVP capture sequencer: sensor power-up, frame-gated capture enable, overflow error.
// Optional: DVP_SEQ_AUTO_PWDN_EN powers the sensor down on every return to IDLE.
module dvp_capture_seq #(
  parameter int P_WAIT_WIDTH  = 20,
  parameter int P_PWUP_CYCLES = 1024,
  parameter int P_RST_CYCLES  = 8192,
  parameter int P_FCNT_WIDTH  = 16
) (
  input  logic                    i_axi_clk,
  input  logic                    i_axi_rst,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [P_FCNT_WIDTH-1:0] i_frame_num,
  input  logic                    i_vsync_pulse,
  input  logic                    i_fifo_ovf,
  output logic                    o_dvp_pwdn,
  output logic                    o_dvp_resetb,
  output logic                    o_dvp_ena,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [P_FCNT_WIDTH-1:0] o_frame_cnt,
  output logic [2:0]              o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PWRUP   = 3'd1,
    S_RSTREL  = 3'd2,
    S_ARM     = 3'd3,
    S_CAPTURE = 3'd4,
    S_ERROR   = 3'd6
  } state_t;

  state_t                  state, state_n;
  logic [P_WAIT_WIDTH-1:0] wait_cnt, wait_n;
  logic [P_FCNT_WIDTH-1:0] frame_lat, frame_lat_n, cnt_n, cnt_inc;
  logic                    powered, powered_n, stop_pend, stop_pend_n;
  logic                    pwdn_n, resetb_n, ena_n, done_n, err_n;
  logic                    last_frame;

  assign cnt_inc    = o_frame_cnt + P_FCNT_WIDTH'(1);
  // frame_lat of zero selects continuous capture
  assign last_frame = (frame_lat != '0) && (cnt_inc == frame_lat);
  assign o_state    = state;

  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      frame_lat    <= '0;
      powered      <= 1'b0;
      stop_pend    <= 1'b0;
      o_dvp_pwdn   <= 1'b1;
      o_dvp_resetb <= 1'b0;
      o_dvp_ena    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      state        <= state_n;
      wait_cnt     <= wait_n;
      frame_lat    <= frame_lat_n;
      powered      <= powered_n;
      stop_pend    <= stop_pend_n;
      o_dvp_pwdn   <= pwdn_n;
      o_dvp_resetb <= resetb_n;
      o_dvp_ena    <= ena_n;
      o_busy       <= (state_n != S_IDLE) && (state_n != S_ERROR);
      o_done       <= done_n;
      o_err        <= err_n;
      o_frame_cnt  <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    wait_n      = wait_cnt + P_WAIT_WIDTH'(1);
    frame_lat_n = frame_lat;
    powered_n   = powered;
    stop_pend_n = stop_pend;
    pwdn_n      = o_dvp_pwdn;
    resetb_n    = o_dvp_resetb;
    ena_n       = o_dvp_ena;
    done_n      = 1'b0;
    err_n       = o_err;
    cnt_n       = o_frame_cnt;

    case (state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          frame_lat_n = i_frame_num;
          cnt_n       = '0;
          if (powered) begin
            state_n = S_ARM;
          end else begin
            state_n = S_PWRUP;
            pwdn_n  = 1'b0;
          end
        end
      end
      S_PWRUP: begin
        if (i_stop) begin
          state_n   = S_IDLE;
          pwdn_n    = 1'b1;
          resetb_n  = 1'b0;
          powered_n = 1'b0;
        end else if (wait_cnt == P_WAIT_WIDTH'(P_PWUP_CYCLES - 1)) begin
          state_n  = S_RSTREL;
          resetb_n = 1'b1;
        end
      end
      S_RSTREL: begin
        if (i_stop) begin
          state_n   = S_IDLE;
          pwdn_n    = 1'b1;
          resetb_n  = 1'b0;
          powered_n = 1'b0;
        end else if (wait_cnt == P_WAIT_WIDTH'(P_RST_CYCLES - 1)) begin
          state_n   = S_ARM;
          powered_n = 1'b1;
        end
      end
      S_ARM: begin
        if (i_fifo_ovf) begin
          state_n = S_ERROR;
          ena_n   = 1'b0;
          err_n   = 1'b1;
        end else if (i_vsync_pulse) begin
          state_n     = S_CAPTURE;
          ena_n       = 1'b1;
          stop_pend_n = 1'b0;
        end else if (i_stop) begin
          state_n = S_IDLE;
        end
      end
      S_CAPTURE: begin
        // overflow outranks a coincident vsync or stop
        if (i_fifo_ovf) begin
          state_n = S_ERROR;
          ena_n   = 1'b0;
          err_n   = 1'b1;
        end else if (i_vsync_pulse) begin
          cnt_n = cnt_inc;
          if (last_frame || stop_pend || i_stop) begin
            state_n = S_IDLE;
            ena_n   = 1'b0;
            done_n  = 1'b1;
          end
        end else if (i_stop) begin
          stop_pend_n = 1'b1;
        end
      end
      S_ERROR: begin
        if (i_stop) begin
          state_n = S_IDLE;
          err_n   = 1'b0;
        end else if (i_start) begin
          state_n     = S_ARM;
          err_n       = 1'b0;
          frame_lat_n = i_frame_num;
          cnt_n       = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

`ifdef DVP_SEQ_AUTO_PWDN_EN
    if (state_n == S_IDLE && state != S_IDLE) begin
      pwdn_n    = 1'b1;
      resetb_n  = 1'b0;
      powered_n = 1'b0;
    end
`endif

    if (state_n != state) begin
      wait_n = '0;
    end
  end

endmodule

// File: tb/tb_dvp_capture_seq.sv
// tb/tb_dvp_capture_seq.sv - directed self-checking bench for dvp_capture_seq.
module tb_dvp_capture_seq;

`ifdef DVP_SEQ_AUTO_PWDN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, vsync = 1'b0, ovf = 1'b0;
  logic [15:0] frame_num = '0;
  logic        pwdn, resetb, ena, busy, done, err;
  logic [15:0] frame_cnt;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dvp_capture_seq #(
    .P_WAIT_WIDTH(20), .P_PWUP_CYCLES(4), .P_RST_CYCLES(8), .P_FCNT_WIDTH(16)
  ) dut (
    .i_axi_clk(clk), .i_axi_rst(rst), .i_start(start), .i_stop(stop),
    .i_frame_num(frame_num), .i_vsync_pulse(vsync), .i_fifo_ovf(ovf),
    .o_dvp_pwdn(pwdn), .o_dvp_resetb(resetb), .o_dvp_ena(ena), .o_busy(busy),
    .o_done(done), .o_err(err), .o_frame_cnt(frame_cnt), .o_state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] n, input bit pw);
    frame_num = n;
    start     = 1'b1;
    step();
    start     = 1'b0;
    check("start_cnt_clr", 32'(frame_cnt), 0);
    check("start_state", 32'(state), (pw && !AUTO) ? 3 : 1);
    if (!(pw && !AUTO)) begin
      check("pwup_pwdn", 32'(pwdn), 0);
      check("pwup_resetb_low", 32'(resetb), 0);
      repeat (3) step();
      check("pwup_hold", 32'(state), 1);
      step();
      check("resetb_rise", 32'(resetb), 1);
      check("rstrel_state", 32'(state), 2);
      repeat (7) step();
      check("rstrel_hold", 32'(state), 2);
      step();
      check("arm_state", 32'(state), 3);
    end
  endtask

  initial begin
    step();
    step();
    check("rst_pwdn", 32'(pwdn), 1);
    check("rst_resetb", 32'(resetb), 0);
    check("rst_ena", 32'(ena), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check("rst_state", 32'(state), 0);
    rst = 1'b0;
    step();

    // cold start, two frames, vsync every 50 cycles
    start_run(16'd2, 1'b0);
    check("arm_busy", 32'(busy), 1);
    repeat (49) step();
    pulse_vsync();
    check("cap_state", 32'(state), 4);
    check("ena_rise", 32'(ena), 1);
    check("cap_cnt0", 32'(frame_cnt), 0);
    repeat (49) step();
    pulse_vsync();
    check("cap_cnt1", 32'(frame_cnt), 1);
    check("cap_ena_hold", 32'(ena), 1);
    check("cap_nodone", 32'(done), 0);
    repeat (49) step();
    pulse_vsync();
    check("fin_cnt", 32'(frame_cnt), 2);
    check("fin_ena", 32'(ena), 0);
    check("fin_done", 32'(done), 1);
    check("fin_state", 32'(state), 0);
    check("fin_busy", 32'(busy), 0);
    step();
    check("done_pulse_end", 32'(done), 0);
    check("cnt_hold_idle", 32'(frame_cnt), 2);
    check("pwdn_after_done", 32'(pwdn), AUTO ? 1 : 0);
    check("resetb_after_done", 32'(resetb), AUTO ? 0 : 1);

    // warm start, one frame
    start_run(16'd1, 1'b1);
    pulse_vsync();
    pulse_vsync();
    check("one_cnt", 32'(frame_cnt), 1);
    check("one_done", 32'(done), 1);
    check("one_state", 32'(state), 0);

    // overflow coincident with vsync at count 3
    start_run(16'd10, 1'b1);
    pulse_vsync();
    repeat (3) pulse_vsync();
    check("pre_ovf_cnt", 32'(frame_cnt), 3);
    ovf = 1'b1;
    vsync = 1'b1;
    step();
    ovf = 1'b0;
    vsync = 1'b0;
    check("ovf_state", 32'(state), 6);
    check("ovf_err", 32'(err), 1);
    check("ovf_ena", 32'(ena), 0);
    check("ovf_cnt", 32'(frame_cnt), 3);
    check("ovf_nodone", 32'(done), 0);
    check("ovf_busy", 32'(busy), 0);
    step();
    check("err_sticky", 32'(err), 1);
    frame_num = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_err", 32'(err), 0);
    check("restart_state", 32'(state), 3);
    check("restart_cnt", 32'(frame_cnt), 0);
    check("restart_pwdn", 32'(pwdn), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("arm_stop_state", 32'(state), 0);
    check("arm_stop_nodone", 32'(done), 0);

    // continuous mode with wrap, then stop mid-frame
    start_run(16'd0, 1'b1);
    pulse_vsync();
    vsync = 1'b1;
    repeat (65535) step();
    vsync = 1'b0;
    check("cont_ffff", 32'(frame_cnt), 32'hFFFF);
    check("cont_state", 32'(state), 4);
    pulse_vsync();
    check("cont_wrap", 32'(frame_cnt), 0);
    check("cont_ena", 32'(ena), 1);
    repeat (3) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_ena_hold", 32'(ena), 1);
    check("stop_state_hold", 32'(state), 4);
    repeat (5) step();
    check("stop_nodone", 32'(done), 0);
    pulse_vsync();
    check("stop_done", 32'(done), 1);
    check("stop_ena_off", 32'(ena), 0);
    check("stop_cnt", 32'(frame_cnt), 1);
    check("stop_idle", 32'(state), 0);

    // asynchronous reset in the middle of a capture
    start_run(16'd0, 1'b1);
    pulse_vsync();
    pulse_vsync();
    check("pre_rst_cnt", 32'(frame_cnt), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pwdn", 32'(pwdn), 1);
    check("arst_resetb", 32'(resetb), 0);
    check("arst_ena", 32'(ena), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_cnt", 32'(frame_cnt), 0);
    check("arst_state", 32'(state), 0);
    step();
    rst = 1'b0;
    step();

    // stop during RSTREL aborts and powers down
    frame_num = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    check("abort_pre_state", 32'(state), 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_state", 32'(state), 0);
    check("abort_pwdn", 32'(pwdn), 1);
    check("abort_resetb", 32'(resetb), 0);
    check("abort_busy", 32'(busy), 0);
    step();
    start_run(16'd1, 1'b0);
    pulse_vsync();
    pulse_vsync();
    check("post_abort_done", 32'(done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
